// File: rtl/framebuffer_arbiter.sv
// Shares the single-port framebuffer RAM between VGA scan-out reads and CPU pixel writes.
// Define FB_ARB_STEAL_EN to let a long-waiting CPU write steal a display slot.
module framebuffer_arbiter #(
  parameter int ColorBits = 3,
  parameter int screenX   = 320,
  parameter int screenY   = 240,
  parameter int AddrBits  = 17,
  parameter int MaxWait   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [9:0]           posicionX,
  input  logic [9:0]           posicionY,
  input  logic                 cpuWriteReq,
  input  logic [AddrBits-1:0]  cpuWriteAddr,
  input  logic [ColorBits-1:0] cpuWriteData,
  output logic                 cpuWriteAck,
  output logic                 cpuAddrError,
  output logic [AddrBits-1:0]  memAddr,
  output logic [ColorBits-1:0] memWriteData,
  output logic                 memWriteEnable,
  input  logic [ColorBits-1:0] memReadData,
  output logic [ColorBits-1:0] pixelValue
);

  typedef enum logic {GRANT_DISP = 1'b0, GRANT_CPU = 1'b1} grant_e;
  typedef enum logic [1:0] {SLOT_NONE = 2'd0, SLOT_READ = 2'd1, SLOT_STEAL = 2'd2} slot_e;

  localparam logic [9:0]          c_x_lim     = 10'(screenX);
  localparam logic [9:0]          c_y_lim     = 10'(screenY);
  localparam logic [AddrBits-1:0] c_width     = AddrBits'(screenX);
  localparam logic [AddrBits-1:0] c_fb_pixels = AddrBits'(screenX * screenY);

  if ((longint'(1) << AddrBits) < longint'(screenX) * longint'(screenY)) begin : g_bad_addr_bits
    $error("AddrBits too small for screenX*screenY");
  end
  if (MaxWait < 1 || MaxWait > 255) begin : g_bad_max_wait
    $error("MaxWait must be in 1..255");
  end

  grant_e                r_state, w_state_next;
  slot_e                 r_slot_s1, r_slot_s2, w_slot_next;
  logic [AddrBits-1:0]   r_mem_addr, w_mem_addr_next;
  logic [ColorBits-1:0]  r_mem_wdata, w_mem_wdata_next;
  logic                  r_mem_we, w_mem_we_next;
  logic                  r_addr_err, w_addr_err_next;
  logic [ColorBits-1:0]  r_pixel, w_pixel_next;

  logic                  w_active;
  logic [AddrBits-1:0]   w_disp_addr;
  logic                  w_addr_ok;
  logic                  w_cpu_eligible;
  logic                  w_grant_cpu;

  assign w_active       = (posicionX < c_x_lim) && (posicionY < c_y_lim);
  assign w_disp_addr    = AddrBits'(posicionY) * c_width + AddrBits'(posicionX);
  assign w_addr_ok      = cpuWriteAddr < c_fb_pixels;
  // The ack cycle itself blocks a new grant, which caps CPU writes at one per two cycles.
  assign w_cpu_eligible = cpuWriteReq && (r_state == GRANT_DISP);

`ifdef FB_ARB_STEAL_EN
  localparam logic [7:0] c_max_wait = 8'(MaxWait);

  logic [7:0] r_wait_count, w_wait_next;
  logic       w_wait_done;

  assign w_wait_done = (r_wait_count == c_max_wait);
  assign w_grant_cpu = w_cpu_eligible && (!w_active || w_wait_done);

  always_comb begin
    w_wait_next = r_wait_count;
    if (!cpuWriteReq || w_grant_cpu) begin
      w_wait_next = '0;
    end else if (!w_wait_done) begin
      w_wait_next = r_wait_count + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait_count <= '0;
    end else begin
      r_wait_count <= w_wait_next;
    end
  end
`else
  assign w_grant_cpu = w_cpu_eligible && !w_active;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = GRANT_DISP;
    w_mem_addr_next  = w_active ? w_disp_addr : '0;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_we_next    = 1'b0;
    w_addr_err_next  = 1'b0;
    w_slot_next      = w_active ? SLOT_READ : SLOT_NONE;
    if (w_grant_cpu) begin
      w_state_next     = GRANT_CPU;
      w_mem_addr_next  = cpuWriteAddr;
      w_mem_wdata_next = cpuWriteData;
      w_mem_we_next    = w_addr_ok;
      w_addr_err_next  = !w_addr_ok;
      w_slot_next      = w_active ? SLOT_STEAL : SLOT_NONE;
    end
  end

  // A stolen slot never read the RAM, so the mapper keeps seeing the last good pixel.
  always_comb begin
    w_pixel_next = '0;
    case (r_slot_s2)
      SLOT_READ:  w_pixel_next = memReadData;
      SLOT_STEAL: w_pixel_next = r_pixel;
      default:    w_pixel_next = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= GRANT_DISP;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_addr_err  <= 1'b0;
      r_slot_s1   <= SLOT_NONE;
      r_slot_s2   <= SLOT_NONE;
      r_pixel     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_we    <= w_mem_we_next;
      r_addr_err  <= w_addr_err_next;
      r_slot_s1   <= w_slot_next;
      r_slot_s2   <= r_slot_s1;
      r_pixel     <= w_pixel_next;
    end
  end

  assign cpuWriteAck    = (r_state == GRANT_CPU);
  assign cpuAddrError   = r_addr_err;
  assign memAddr        = r_mem_addr;
  assign memWriteData   = r_mem_wdata;
  assign memWriteEnable = r_mem_we;
  assign pixelValue     = r_pixel;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a registered-read RAM model behind the memory port.
module tb_framebuffer_arbiter;

  logic        clock;
  logic        reset;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        req;
  logic [16:0] waddr;
  logic [2:0]  wdata;
  logic        ack;
  logic        err;
  logic [16:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        we;
  logic [2:0]  rdata;
  logic [2:0]  pixel;

  logic [2:0]  ram [0:131071];

  int checks;
  int failures;

  framebuffer_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .posicionX      (pos_x),
    .posicionY      (pos_y),
    .cpuWriteReq    (req),
    .cpuWriteAddr   (waddr),
    .cpuWriteData   (wdata),
    .cpuWriteAck    (ack),
    .cpuAddrError   (err),
    .memAddr        (mem_addr),
    .memWriteData   (mem_wdata),
    .memWriteEnable (we),
    .memReadData    (rdata),
    .pixelValue     (pixel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (we) ram[mem_addr] <= mem_wdata;
    rdata <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (mem_addr !== 17'd0) begin failures++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr); end
    checks++; if (mem_wdata !== 3'd0) begin failures++; $display("FAIL rst_mem_wdata got=%0d exp=0", mem_wdata); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", we); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (pixel !== 3'd0) begin failures++; $display("FAIL rst_pixel got=%0d exp=0", pixel); end
    tick();
    reset = 1'b1;
    pos_x = 10'd320; pos_y = 10'd0; req = 1'b1; waddr = 17'd7; wdata = 3'd5;
    tick();
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL pre_rst_ack got=%b exp=1", ack); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({ack, we, err, mem_addr, mem_wdata, pixel} !== 29'd0) begin
      failures++; $display("FAIL async_rst_outputs got=%h exp=0", {ack, we, err, mem_addr, mem_wdata, pixel});
    end
    tick();
    tick();
    checks++; if (ack !== 1'b0 || we !== 1'b0) begin failures++; $display("FAIL held_rst_ack got=%b%b exp=00", ack, we); end
    pos_x = 10'd10; pos_y = 10'd3;
    reset = 1'b1;
    tick();
    checks++; if (mem_addr !== 17'd970) begin failures++; $display("FAIL post_rst_addr got=%0d exp=970", mem_addr); end
    checks++; if (ack !== 1'b0 || we !== 1'b0) begin failures++; $display("FAIL post_rst_ack got=%b%b exp=00", ack, we); end
    req = 1'b0;
    tick();
  endtask

  task automatic test_display_read();
    logic [9:0]  vx   [8] = '{10'd5, 10'd6, 10'd319, 10'd320, 10'd0, 10'd319, 10'd0, 10'd320};
    logic [9:0]  vy   [8] = '{10'd2, 10'd2, 10'd239, 10'd0, 10'd240, 10'd0, 10'd239, 10'd240};
    logic [16:0] vadr [8] = '{17'd645, 17'd646, 17'd76799, 17'd0, 17'd0, 17'd319, 17'd76480, 17'd0};
    logic [2:0]  vpix [8] = '{3'd5, 3'd2, 3'd6, 3'd0, 3'd0, 3'd7, 3'd1, 3'd0};
    logic        vact [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin pos_x = vx[i]; pos_y = vy[i]; end
      else begin pos_x = 10'd320; pos_y = 10'd0; end
      tick();
      if (i < 8 && vact[i]) begin
        checks++; if (mem_addr !== vadr[i]) begin failures++; $display("FAIL disp_addr[%0d] got=%0d exp=%0d", i, mem_addr, vadr[i]); end
      end
      if (i >= 2) begin
        checks++; if (pixel !== vpix[i-2]) begin failures++; $display("FAIL disp_pixel[%0d] got=%0d exp=%0d", i-2, pixel, vpix[i-2]); end
      end
    end
  endtask

  task automatic test_cpu_write();
    pos_x = 10'd320; pos_y = 10'd0;
    req = 1'b1; waddr = 17'd100; wdata = 3'b011;
    tick();
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL wr_we got=%b exp=1", we); end
    checks++; if (mem_addr !== 17'd100) begin failures++; $display("FAIL wr_addr got=%0d exp=100", mem_addr); end
    checks++; if (mem_wdata !== 3'b011) begin failures++; $display("FAIL wr_data got=%0d exp=3", mem_wdata); end
    checks++; if (ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL wr_ack_err got=%b%b exp=10", ack, err); end
    req = 1'b0;
    tick();
    checks++; if (ack !== 1'b0 || we !== 1'b0) begin failures++; $display("FAIL wr_pulse_end got=%b%b exp=00", ack, we); end
    pos_x = 10'd100;
    tick(); tick(); tick();
    checks++; if (pixel !== 3'b011) begin failures++; $display("FAIL wr_readback got=%0d exp=3", pixel); end
  endtask

  task automatic test_addr_error();
    pos_x = 10'd320; pos_y = 10'd0;
    req = 1'b1; waddr = 17'd76799; wdata = 3'b001;
    tick();
    checks++; if ({ack, err, we} !== 3'b101) begin failures++; $display("FAIL last_addr_ok got=%b exp=101", {ack, err, we}); end
    req = 1'b0;
    tick();
    req = 1'b1; waddr = 17'd76800; wdata = 3'b111;
    tick();
    checks++; if ({ack, err, we} !== 3'b110) begin failures++; $display("FAIL addr_error got=%b exp=110", {ack, err, we}); end
    req = 1'b0;
    tick();
    checks++; if ({ack, err, we} !== 3'b000) begin failures++; $display("FAIL addr_error_end got=%b exp=000", {ack, err, we}); end
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    pos_x = 10'd320; pos_y = 10'd0;
    req = 1'b1; waddr = 17'd200; wdata = 3'b100;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack === 1'b1) acks++;
      checks++; if (ack !== ((i % 2) == 0)) begin failures++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, ack, (i % 2) == 0); end
    end
    checks++; if (acks != 3) begin failures++; $display("FAIL b2b_total got=%0d exp=3", acks); end
    req = 1'b0;
    tick();
  endtask

`ifdef FB_ARB_STEAL_EN
  task automatic test_steal();
    logic [2:0] exp_pix;
    logic [2:0] exp_prev;
    int cnt;
    exp_prev = 3'd0;
    pos_y = 10'd5; pos_x = 10'd11; req = 1'b0;
    waddr = 17'd300; wdata = 3'b110;
    tick(); tick();
    for (int k = 1; k <= 20; k++) begin
      pos_x = 10'(10 + k);
      req = (k <= 16);
      tick();
      checks++; if (ack !== (k == 16)) begin failures++; $display("FAIL steal_ack[%0d] got=%b exp=%b", k, ack, k == 16); end
      if (k == 16) begin
        checks++; if (we !== 1'b1 || mem_addr !== 17'd300) begin failures++; $display("FAIL steal_write got we=%b addr=%0d exp we=1 addr=300", we, mem_addr); end
      end
      if (k >= 3) begin
        exp_pix = (k - 2 == 16) ? exp_prev : 3'(((8 + k) % 7) + 1);
        checks++; if (pixel !== exp_pix) begin failures++; $display("FAIL steal_pixel[%0d] got=%0d exp=%0d", k, pixel, exp_pix); end
        exp_prev = exp_pix;
      end
    end
    pos_x = 10'd10; req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (ack === 1'b1) break;
    end
    checks++; if (cnt != 16) begin failures++; $display("FAIL steal_rewait got=%0d exp=16", cnt); end
    req = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_steal();
    int acks;
    acks = 0;
    pos_y = 10'd5; pos_x = 10'd10;
    req = 1'b1; waddr = 17'd300; wdata = 3'b110;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL active_blocks_cpu got=%0d exp=0", acks); end
    pos_x = 10'd320;
    tick();
    checks++; if (ack !== 1'b1 || we !== 1'b1 || mem_addr !== 17'd300) begin
      failures++; $display("FAIL blank_grant got ack=%b we=%b addr=%0d exp 1 1 300", ack, we, mem_addr);
    end
    req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0;
    pos_x = 10'd0; pos_y = 10'd0; req = 1'b0; waddr = '0; wdata = '0;
    for (int a = 0; a < 131072; a++) ram[a] = 3'd0;
    ram[645] = 3'd5; ram[646] = 3'd2; ram[76799] = 3'd6; ram[319] = 3'd7; ram[76480] = 3'd1;
    for (int x = 11; x <= 30; x++) ram[1600 + x] = 3'((x % 7) + 1);
    #1;
    test_reset();
    test_display_read();
    test_cpu_write();
    test_addr_error();
    test_back_to_back();
`ifdef FB_ARB_STEAL_EN
    test_steal();
`else
    test_no_steal();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares the single-port framebuffer RAM between the VGA scan-out path and the ASIP pixel-write port. Converts the scan position into a linear framebuffer address, issues display reads and CPU writes under a fixed-priority policy with an optional anti-starvation slot steal, and delivers the read pixel value to the colour-mapping stage. Sits between the VGA timing generator, the framebuffer RAM and the pixel colour mapper.

## Interface
- ColorBits, 3, bits per stored pixel
- screenX, 320, active framebuffer width in pixels
- screenY, 240, active framebuffer height in pixels
- AddrBits, 17, framebuffer address width; must satisfy 2^AddrBits >= screenX*screenY
- MaxWait, 15, cycles a CPU request may wait before a slot steal (1..255)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- posicionX  in  10  current scan column
- posicionY  in  10  current scan row
- cpuWriteReq  in  1  CPU write request, level
- cpuWriteAddr  in  AddrBits  linear pixel address
- cpuWriteData  in  ColorBits  pixel value to store
- cpuWriteAck  out  1  one-cycle write-issued pulse
- cpuAddrError  out  1  one-cycle pulse: acked address was out of range, write dropped
- memAddr  out  AddrBits  RAM address, registered
- memWriteData  out  ColorBits  RAM write data, registered
- memWriteEnable  out  1  RAM write strobe, registered
- memReadData  in  ColorBits  RAM read data, valid one cycle after memAddr
- pixelValue  out  ColorBits  pixel to colour mapper, registered

## Operation
- Region active when posicionX < screenX and posicionY < screenY, sampled each edge.
- Display address = posicionY*screenX + posicionX, computed at AddrBits width; evaluated only when active, so no overflow.
- Per-cycle grant, two states: GRANT_DISP (memWriteEnable=0, memAddr=display address) and GRANT_CPU (memWriteEnable=1, memAddr/memWriteData from CPU port).
- Grant rule at each edge: CPU if cpuWriteReq=1 and cpuWriteAck=0 and (region inactive, or waitCount = MaxWait); otherwise display.
- GRANT_CPU with cpuWriteAddr >= screenX*screenY: memWriteEnable stays 0, cpuWriteAck=1 and cpuAddrError=1.
- waitCount (8 bit): +1 per cycle a request is pending and not granted, saturates at MaxWait, cleared on CPU grant or request drop.
- Read-valid pipeline tracks each display slot; pixelValue loads memReadData for valid in-region reads, loads 0 for out-of-region slots, holds its previous value for a stolen slot.
- No back-to-back CPU writes: request seen while cpuWriteAck=1 is ignored that cycle; peak rate one write per 2 cycles.

## Timing
- Reset (asynchronous assert): memAddr=0, memWriteData=0, memWriteEnable=0, cpuWriteAck=0, cpuAddrError=0, pixelValue=0, waitCount=0, pipeline valid=0, state GRANT_DISP. Pending CPU request is discarded; requester must hold or re-present it after release.
- Display latency: position sampled at edge E -> memAddr at E -> memReadData during cycle after E+1 -> pixelValue at edge E+2. Fixed 2-edge latency after sample; timing generator compensates.
- CPU handshake: requester holds cpuWriteReq, cpuWriteAddr, cpuWriteData stable until cpuWriteAck seen; ack, memWriteEnable and memAddr register on the same edge; requester drops or changes request at the next edge.
- Simultaneous active region and request with waitCount < MaxWait: display wins.
- Region boundaries: X=screenX-1 is active, X=screenX inactive; same for Y.

## Configuration
- FB_ARB_STEAL_EN defined: waitCount and slot-steal logic present as described; worst-case CPU wait MaxWait+1 cycles.
- Not defined: waitCount removed; CPU granted only when region inactive; pixelValue never holds for a steal; cpuWriteAck otherwise identical.

## Test plan
- Reset low mid-write with cpuWriteReq=1 -> all outputs 0 immediately; after release, first active slot reads address Y*320+X, no ack before release.
- Scan X=5,Y=2, RAM preloaded 3'b101 at 645 -> memAddr=645, pixelValue=3'b101 two edges later.
- Request addr=100, data=3'b011 with X=320 (blanking) -> next edge memWriteEnable=1, memAddr=100, memWriteData=3'b011, cpuWriteAck=1 for one cycle.
- Request held in continuous active region, MaxWait=15 (STEAL_EN) -> write issued on 16th cycle; pixelValue repeats previous value for that slot; waitCount returns to 0.
- Request addr=76800 during blanking -> cpuWriteAck=1, cpuAddrError=1, memWriteEnable=0.
- Request held high for 6 cycles in blanking -> exactly 3 acks, alternate cycles.
